// File: rtl/forwarding_unit_pkg.sv
// Shared forwarding definitions: operand-select encodings and the hard-wired zero register.
// Also imported by the EX operand multiplexers so both sides agree on the encoding.
package forwarding_unit_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forwarding_unit_if.sv
// Pipeline-side bundle of the forwarding unit: ID/EX register fields in, forward selects and stall out.
// The slave modport is the forwarding unit; the master modport is the pipeline/hazard logic.
interface forwarding_unit_if #(
  parameter int FORW_ALU = 2,
  parameter int REG_ADDR = 5,
  parameter int CNT_SZ   = 16
);

  logic                i_enable;
  logic                i_flush_E;
  logic [REG_ADDR-1:0] i_instr_rs_D;
  logic [REG_ADDR-1:0] i_instr_rt_D;
  logic [REG_ADDR-1:0] i_write_reg_E;
  logic                i_reg_write_E;
  logic                i_mem_read_E;
  logic [FORW_ALU-1:0] o_forward_a_FU;
  logic [FORW_ALU-1:0] o_forward_b_FU;
  logic                o_stall_HU;
  logic [CNT_SZ-1:0]   o_stall_cnt;

  modport slave (
    input  i_enable, i_flush_E, i_instr_rs_D, i_instr_rt_D,
    input  i_write_reg_E, i_reg_write_E, i_mem_read_E,
    output o_forward_a_FU, o_forward_b_FU, o_stall_HU, o_stall_cnt
  );

  modport master (
    output i_enable, i_flush_E, i_instr_rs_D, i_instr_rt_D,
    output i_write_reg_E, i_reg_write_E, i_mem_read_E,
    input  o_forward_a_FU, o_forward_b_FU, o_stall_HU, o_stall_cnt
  );

endinterface

// File: rtl/forwarding_unit_fwd_select.sv
// Priority compare of one EX source register against the MEM and WB shadow destinations.
// The MEM producer is younger than the WB producer, so a MEM hit wins.
module forwarding_unit_fwd_select
  import forwarding_unit_pkg::*;
#(
  parameter int FORW_ALU = 2,
  parameter int REG_ADDR = 5
) (
  input  logic [REG_ADDR-1:0] i_src,
  input  logic [REG_ADDR-1:0] i_mem_rd,
  input  logic                i_mem_rw,
  input  logic [REG_ADDR-1:0] i_wb_rd,
  input  logic                i_wb_rw,
  output logic [FORW_ALU-1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // r0 is hard-wired, so a write to it must never be forwarded.
  assign w_mem_hit = i_mem_rw && (i_mem_rd != REG_ADDR'(REG_ZERO)) && (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_rw  && (i_wb_rd  != REG_ADDR'(REG_ZERO)) && (i_wb_rd  == i_src);

  always_comb begin
    o_sel = FORW_ALU'(FWD_REG);
    if (w_mem_hit) begin
      o_sel = FORW_ALU'(FWD_MEM);
    end else if (w_wb_hit) begin
      o_sel = FORW_ALU'(FWD_WB);
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage forwarding unit: shadows rs/rt and destination tags down the pipe, drives forward
// selects from registered state only, and flags load-use hazards with a saturating stall count.
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int FORW_ALU = 2,
  parameter int REG_ADDR = 5,
  parameter int CNT_SZ   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  forwarding_unit_if.slave  bus
);

  logic [REG_ADDR-1:0] r_ex_rs;
  logic [REG_ADDR-1:0] r_ex_rt;
  logic [REG_ADDR-1:0] r_mem_rd;
  logic                r_mem_rw;
  logic [REG_ADDR-1:0] r_wb_rd;
  logic                r_wb_rw;
  logic [CNT_SZ-1:0]   r_stall_cnt;

  logic                w_stall;
  logic [FORW_ALU-1:0] w_fwd_a;
  logic [FORW_ALU-1:0] w_fwd_b;

  function automatic logic [CNT_SZ-1:0] sat_inc(input logic [CNT_SZ-1:0] v);
    return (&v) ? v : v + CNT_SZ'(1);
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  assign w_stall = bus.i_mem_read_E
                && (bus.i_write_reg_E != REG_ADDR'(REG_ZERO))
                && ((bus.i_write_reg_E == bus.i_instr_rs_D)
                 || (bus.i_write_reg_E == bus.i_instr_rt_D));

  // ID->EX, EX->MEM and MEM->WB shadow stages
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_mem_rd    <= '0;
      r_mem_rw    <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_rw     <= 1'b0;
      r_stall_cnt <= '0;
    end else if (bus.i_enable) begin
      r_mem_rd <= bus.i_write_reg_E;
      r_mem_rw <= bus.i_reg_write_E;
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
      if (w_stall || bus.i_flush_E) begin
        r_ex_rs <= '0;
        r_ex_rt <= '0;
      end else begin
        r_ex_rs <= bus.i_instr_rs_D;
        r_ex_rt <= bus.i_instr_rt_D;
      end
      if (w_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  forwarding_unit_fwd_select #(.FORW_ALU(FORW_ALU), .REG_ADDR(REG_ADDR)) u_fwd_a (
    .i_src    (r_ex_rs),
    .i_mem_rd (r_mem_rd),
    .i_mem_rw (r_mem_rw),
    .i_wb_rd  (r_wb_rd),
    .i_wb_rw  (r_wb_rw),
    .o_sel    (w_fwd_a)
  );

  forwarding_unit_fwd_select #(.FORW_ALU(FORW_ALU), .REG_ADDR(REG_ADDR)) u_fwd_b (
    .i_src    (r_ex_rt),
    .i_mem_rd (r_mem_rd),
    .i_mem_rw (r_mem_rw),
    .i_wb_rd  (r_wb_rd),
    .i_wb_rw  (r_wb_rw),
    .o_sel    (w_fwd_b)
  );

  assign bus.o_forward_a_FU = w_fwd_a;
  assign bus.o_forward_b_FU = w_fwd_b;
  assign bus.o_stall_HU     = w_stall;
  assign bus.o_stall_cnt    = r_stall_cnt;

endmodule
